// File: rtl/tap_event_counter_bank_if.sv
// DR-side command/readout bus of tap_event_counter_bank.
// The DR decoder pushes 8-bit commands as one-cycle strobes; the DR encoder
// samples the tagged counter word.
// Handshake: inbound_valid is a single-cycle qualifier for inbound_data with
// no ready/backpressure -- a command is consumed on every tck edge where
// inbound_valid=1. outbound_data is a free-running registered word with no
// valid; the encoder samples it at Capture-DR.
interface tap_event_counter_bank_if #(
  parameter int OUT_WIDTH = 32
) ();
  logic                 inbound_valid;
  logic [7:0]           inbound_data;
  logic [OUT_WIDTH-1:0] outbound_data;

  // DR decoder/encoder side
  modport master (
    output inbound_valid,
    output inbound_data,
    input  outbound_data
  );

  // Counter bank side
  modport slave (
    input  inbound_valid,
    input  inbound_data,
    output outbound_data
  );
endinterface

// File: rtl/tap_event_counter_bank.sv
// tap_event_counter_bank: COUNTERS independent event counters clocked by tck,
// controlled by 8-bit commands (SELECT/CLEAR/MODE/SNAPSHOT) and read out as
// {counter_sel, overflow, value} through a registered mux.
// Optional feature macro: TAP_EVENT_COUNTER_SNAPSHOT_EN builds a snapshot
// bank; when undefined, SNAPSHOT commands are ignored and the output always
// shows live counters.
module tap_event_counter_bank #(
  parameter int COUNTERS      = 8,
  parameter int COUNTER_WIDTH = 28,
  parameter int SEL_WIDTH     = $clog2(COUNTERS),
  parameter int OUT_WIDTH     = SEL_WIDTH + 1 + COUNTER_WIDTH
) (
  input  logic                  tck,
  input  logic                  rst_n,
  input  logic [COUNTERS-1:0]   events,
  tap_event_counter_bank_if.slave dr
);

  localparam logic [3:0] OP_SELECT = 4'b1001;
  localparam logic [3:0] OP_CLEAR  = 4'b1100;
  localparam logic [3:0] OP_MODE   = 4'b1011;

  logic [COUNTER_WIDTH-1:0] cnt_q [COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_d [COUNTERS];
  logic [COUNTERS-1:0]      ovf_q, ovf_d;
  logic [SEL_WIDTH-1:0]     sel_q, sel_d;
  logic                     sat_q, sat_d;
  logic [OUT_WIDTH-1:0]     out_q, out_d;

  logic [3:0]               opcode;
  logic [3:0]               arg;
  logic [COUNTERS-1:0]      clr_mask;

`ifdef TAP_EVENT_COUNTER_SNAPSHOT_EN
  localparam logic [3:0] OP_SNAPSHOT = 4'b1010;

  logic [COUNTER_WIDTH-1:0] snap_cnt_q [COUNTERS];
  logic [COUNTER_WIDTH-1:0] snap_cnt_d [COUNTERS];
  logic [COUNTERS-1:0]      snap_ovf_q, snap_ovf_d;
  logic                     snap_act_q, snap_act_d;
`endif

  // Command decode, counter update and output mux selection.
  always_comb begin
    opcode   = dr.inbound_data[7:4];
    arg      = dr.inbound_data[3:0];
    sel_d    = sel_q;
    sat_d    = sat_q;
    clr_mask = '0;

    if (dr.inbound_valid && opcode == OP_SELECT && int'(arg) < COUNTERS)
      sel_d = arg[SEL_WIDTH-1:0];

    if (dr.inbound_valid && opcode == OP_MODE)
      sat_d = arg[0];

    // arg[3] clears all; otherwise arg[2:0] names one channel, and a
    // channel number beyond the bank simply matches nothing.
    for (int i = 0; i < COUNTERS; i++) begin
      if (dr.inbound_valid && opcode == OP_CLEAR &&
          (arg[3] || int'(arg[2:0]) == i))
        clr_mask[i] = 1'b1;
    end

    // Clear beats a same-cycle event; the increment policy follows the
    // mode register as it stood before this edge.
    for (int i = 0; i < COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr_mask[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (events[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          if (!sat_q) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
        end
      end
    end

`ifdef TAP_EVENT_COUNTER_SNAPSHOT_EN
    // Snapshot captures the pre-edge live state, so events and clears
    // arriving in the same cycle are excluded.
    snap_act_d = snap_act_q;
    snap_ovf_d = snap_ovf_q;
    for (int i = 0; i < COUNTERS; i++) snap_cnt_d[i] = snap_cnt_q[i];
    if (dr.inbound_valid && opcode == OP_SNAPSHOT) begin
      snap_act_d = 1'b1;
      snap_ovf_d = ovf_q;
      for (int i = 0; i < COUNTERS; i++) snap_cnt_d[i] = cnt_q[i];
    end

    if (snap_act_q)
      out_d = {sel_q, snap_ovf_q[sel_q], snap_cnt_q[sel_q]};
    else
      out_d = {sel_q, ovf_q[sel_q], cnt_q[sel_q]};
`else
    out_d = {sel_q, ovf_q[sel_q], cnt_q[sel_q]};
`endif
  end

  // State registers; reset clears everything including the output word.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COUNTERS; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
      sel_q <= '0;
      sat_q <= 1'b0;
      out_q <= '0;
`ifdef TAP_EVENT_COUNTER_SNAPSHOT_EN
      for (int i = 0; i < COUNTERS; i++) snap_cnt_q[i] <= '0;
      snap_ovf_q <= '0;
      snap_act_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < COUNTERS; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
      sel_q <= sel_d;
      sat_q <= sat_d;
      out_q <= out_d;
`ifdef TAP_EVENT_COUNTER_SNAPSHOT_EN
      for (int i = 0; i < COUNTERS; i++) snap_cnt_q[i] <= snap_cnt_d[i];
      snap_ovf_q <= snap_ovf_d;
      snap_act_q <= snap_act_d;
`endif
    end
  end

  assign dr.outbound_data = out_q;

endmodule

// File: tb/tb_tap_event_counter_bank.sv
// Bench for tap_event_counter_bank (8 channels x 8 bits): directed scenarios
// followed by randomized events/commands, every cycle compared against an
// integer reference model of the counter bank.
module tb_tap_event_counter_bank;

  localparam int N   = 8;
  localparam int W   = 8;
  localparam int SW  = 3;
  localparam int OW  = SW + 1 + W;
  localparam int MAX = (1 << W) - 1;
`ifdef TAP_EVENT_COUNTER_SNAPSHOT_EN
  localparam bit SNAP_ON = 1'b1;
`else
  localparam bit SNAP_ON = 1'b0;
`endif

  logic         tck;
  logic         rst_n;
  logic [N-1:0] events;

  tap_event_counter_bank_if #(.OUT_WIDTH(OW)) bus ();

  tap_event_counter_bank #(
    .COUNTERS      (N),
    .COUNTER_WIDTH (W)
  ) dut (
    .tck    (tck),
    .rst_n  (rst_n),
    .events (events),
    .dr     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [N];
  bit m_ovf [N];
  int s_cnt [N];
  bit s_ovf [N];
  int m_sel;
  bit m_sat;
  bit m_snap;
  logic [OW-1:0] exp_q[$];

  function automatic logic [OW-1:0] pack(input int sel, input bit f, input int v);
    logic [31:0] s32, v32;
    s32 = sel;
    v32 = v;
    return {s32[SW-1:0], f, v32[W-1:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; s_cnt[i] = 0; s_ovf[i] = 0;
    end
    m_sel  = 0;
    m_sat  = 0;
    m_snap = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // One tck edge of the bank's behaviour, in plain integer terms.
  task automatic model_edge(input logic [7:0] ev, input logic vld, input logic [7:0] cmd);
    int op, arg;
    bit hit;
    if (m_snap) exp_q.push_back(pack(m_sel, s_ovf[m_sel], s_cnt[m_sel]));
    else        exp_q.push_back(pack(m_sel, m_ovf[m_sel], m_cnt[m_sel]));
    op  = vld ? int'(cmd[7:4]) : -1;
    arg = int'(cmd[3:0]);
    if (op == 10 && SNAP_ON) begin
      m_snap = 1;
      for (int i = 0; i < N; i++) begin
        s_cnt[i] = m_cnt[i]; s_ovf[i] = m_ovf[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      hit = (op == 12) && (arg >= 8 || arg == i);
      if (hit) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (ev[i]) begin
        if (m_cnt[i] + 1 > MAX) begin
          m_ovf[i] = 1;
          m_cnt[i] = m_sat ? MAX : (m_cnt[i] + 1) % (MAX + 1);
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (op == 9 && arg < N) m_sel = arg;
    if (op == 11) m_sat = arg[0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] ev, input logic vld, input logic [7:0] cmd);
    logic [OW-1:0] e;
    events            = ev;
    bus.inbound_valid = vld;
    bus.inbound_data  = cmd;
    @(posedge tck);
    model_edge(ev, vld, cmd);
    @(negedge tck);
    void'(exp_q.pop_front());
    e = exp_q[0];
    check_eq("out", 32'(bus.outbound_data), 32'(e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] cmd);
    step(8'h00, 1'b1, cmd);
  endtask

  task automatic pulse(input logic [7:0] ev, input int n);
    for (int i = 0; i < n; i++) step(ev, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ev, cmd;
    logic [3:0] op;
    rst_n             = 1'b0;
    events            = '0;
    bus.inbound_valid = 1'b0;
    bus.inbound_data  = '0;
    model_reset();
    @(negedge tck);
    @(negedge tck);
    check_eq("reset_out", 32'(bus.outbound_data), 32'h0);
    rst_n = 1'b1;

    // free-running count on channel 0
    pulse(8'h01, 100);
    send(8'h90);
    idle(1);
    check_eq("cnt100", 32'(bus.outbound_data), 32'(pack(0, 0, 100)));

    // out-of-range select keeps the tag
    send(8'h99);
    idle(1);
    check_eq("sel_oor", 32'(bus.outbound_data), 32'(pack(0, 0, 100)));

    // wrap then saturate on channel 2
    send(8'h92);
    send(8'hC8);
    pulse(8'h04, 256);
    idle(2);
    check_eq("wrap", 32'(bus.outbound_data), 32'(pack(2, 1, 0)));
    send(8'hB1);
    send(8'hC8);
    pulse(8'h04, 300);
    idle(2);
    check_eq("saturate", 32'(bus.outbound_data), 32'(pack(2, 1, MAX)));

    // clear racing an event on channel 3; channel 4 unaffected
    send(8'hC8);
    send(8'h93);
    pulse(8'h18, 5);
    step(8'h18, 1'b1, 8'hC3);
    idle(1);
    check_eq("clr_race", 32'(bus.outbound_data), 32'(pack(3, 0, 0)));
    pulse(8'h08, 1);
    idle(1);
    check_eq("clr_then_evt", 32'(bus.outbound_data), 32'(pack(3, 0, 1)));
    send(8'h94);
    idle(1);
    check_eq("ch4_kept", 32'(bus.outbound_data), 32'(pack(4, 0, 6)));

    // snapshot behaviour
    send(8'hB0);
    send(8'hC8);
    send(8'h91);
    pulse(8'h02, 50);
    send(8'hA0);
    pulse(8'h02, 20);
    send(8'h91);
    idle(1);
    check_eq("snapshot", 32'(bus.outbound_data), 32'(pack(1, 0, SNAP_ON ? 50 : 70)));

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      ev = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 4))
          0:       op = 4'h9;
          1:       op = 4'hC;
          2:       op = 4'hB;
          3:       op = 4'hA;
          default: op = 4'($urandom_range(0, 15));
        endcase
        cmd = {op, 4'($urandom_range(0, 15))};
        step(ev, 1'b1, cmd);
      end else begin
        step(ev, 1'b0, 8'($urandom_range(0, 255)));
      end
    end

    // asynchronous reset between edges
    pulse(8'hFF, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'(bus.outbound_data), 32'h0);
    model_reset();
    @(negedge tck);
    check_eq("rst_hold", 32'(bus.outbound_data), 32'h0);
    rst_n = 1'b1;
    pulse(8'h01, 10);
    send(8'h90);
    idle(1);
    check_eq("recount", 32'(bus.outbound_data), 32'(pack(0, 0, 10)));

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tap_event_counter_bank.md
# tap_event_counter_bank

Parametrised JTAG-side event counter bank clocked by `tck`. It counts TAP state qualifiers or any other per-cycle event strobes in `COUNTERS` independent channels. Channels are selected, cleared, mode-switched and snapshotted through 8-bit commands from the DR decoder. It presents one tagged word to the DR encoder for shift-out.

## Interface
- `COUNTERS`, 8: number of channels, 2..16.
- `COUNTER_WIDTH`, 28: bits per counter, 8..32.
- `SEL_WIDTH`, `$clog2(COUNTERS)`: channel index width. Derived; do not override.
- `OUT_WIDTH`, `SEL_WIDTH+1+COUNTER_WIDTH`: outbound word width. Derived.

- `tck` in 1: TAP clock. Sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `events` in COUNTERS: per-channel increment strobes, sampled at posedge `tck`. Integrators tie bit 0 high to get a free-running cycle count.
- `inbound_valid` in 1: one-cycle strobe; `inbound_data` holds a command.
- `inbound_data` in 8: command. `[7:4]` is the opcode, `[3:0]` is the argument.
- `outbound_data` out OUT_WIDTH: `{counter_sel, overflow[counter_sel], value}`.

## Operation
- Opcodes are decoded only when `inbound_valid`=1. Unknown opcodes are ignored.
  - `4'b1001` SELECT: `counter_sel <= arg`. If `arg >= COUNTERS`, `counter_sel` is unchanged.
  - `4'b1100` CLEAR: if `arg[3]`=1, clear every counter and overflow flag. Otherwise clear channel `arg[2:0]`, zero-extended against `COUNTERS`; an out-of-range channel is a no-op.
  - `4'b1011` MODE: `saturate <= arg[0]`. 0 = wrap, 1 = saturate. Applies to all channels.
  - `4'b1010` SNAPSHOT: only when `TAP_EVENT_COUNTER_SNAPSHOT_EN` is defined; otherwise ignored.
- Counter `i` increments when `events[i]`=1.
  - Wrap mode: all-ones + 1 gives 0 and sets `overflow[i]`.
  - Saturate mode: the counter holds at all-ones and sets `overflow[i]` on the first increment attempted at all-ones.
- `overflow[i]` is sticky. Only a CLEAR covering channel `i`, or reset, clears it.
- CLEAR and an event on the same channel in the same cycle: CLEAR wins. Result is value 0, flag 0.
- A counter that is not cleared keeps counting in a cycle where another channel is cleared.
- `outbound_data` is a registered mux of the selected channel's value, flag and `counter_sel`. It is sourced from the snapshot when the snapshot feature is active.

## Timing
- Reset asserted: every counter, overflow flag, snapshot register, `counter_sel`, `saturate` and `outbound_data` is forced to 0 asynchronously.
- Reset deassertion is synchronised by the instantiator. The first count occurs on the first posedge `tck` with `rst_n`=1.
- Counter latency: an event sampled at edge N is visible in the counter after edge N. It reaches `outbound_data` after edge N+1.
- SELECT at edge N: `counter_sel` updates after N. `outbound_data` shows the new channel, including its tag, after N+1.
- CLEAR at edge N: the counter reads 0 after N. `outbound_data` shows 0 after N+1. An event in cycle N+1 shows as 1 after N+2.
- MODE takes effect for increments from edge N+1 onward.
- There is no backpressure. The encoder samples `outbound_data` at Capture-DR, so the word must be stable for one cycle beforehand.
- Reset mid-operation: all state returns to reset values immediately, with no partial commands.

## Configuration
- `TAP_EVENT_COUNTER_SNAPSHOT_EN` defined:
  - A snapshot register bank of `COUNTERS×(COUNTER_WIDTH+1)` bits is built.
  - SNAPSHOT at edge N copies every live counter and flag in the same cycle. Events in cycle N are not included.
  - From then on `outbound_data` reflects the snapshot for every selected channel until the next SNAPSHOT or reset.
  - CLEAR affects live counters only, not the snapshot.
- Macro undefined:
  - No snapshot storage is built and opcode `1010` is ignored.
  - `outbound_data` always reflects live counters.

## Test plan
- Reset, then `events`=`8'h01` for 100 cycles, then SELECT 0 (`0x90`) -> `outbound_data` = `{3'd0,1'b0,28'd100+}`. The exact count equals the edges since reset, allowing for the one-cycle output lag.
- SELECT 9 with `COUNTERS`=8 (`0x99`) -> `counter_sel` stays at its prior value and `outbound_data` tag unchanged.
- `COUNTER_WIDTH`=8, wrap mode, 256 events on channel 2 -> value 0, flag 1. Then MODE saturate (`0xB1`), clear all (`0xC8`), 300 events -> value `8'hFF`, flag 1.
- CLEAR channel 3 (`0xC3`) coincident with `events[3]`=1 -> value 0 the next cycle, then 1 after one further event. Channel 4 is unaffected.
- With `TAP_EVENT_COUNTER_SNAPSHOT_EN`: count channel 1 to 50, SNAPSHOT (`0xA0`), 20 more events, SELECT 1 -> output shows 50. Without the macro -> output shows 70.
- Assert `rst_n` mid-count asynchronously, between edges -> `outbound_data` is 0 before the next posedge and counting restarts from 0.
